// File: rtl/seven_segment_4_digits_decoder.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus: debounces segment/strobe
// samples, decodes each accepted pattern to a nibble and reassembles the displayed 16-bit value.
module seven_segment_4_digits_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  abcdefgh,
  input  logic [3:0]  digit,
  output logic [15:0] number,
  output logic        number_valid,
  output logic [3:0]  digit_seen,
  output logic        pattern_error,
  output logic        strobe_error
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  logic [7:0]  s_seg, p_seg;
  logic [3:0]  s_dig, p_dig;
  logic [7:0]  stab;
  logic [15:0] shadow;

  logic        changed;
  logic        accept;
  logic [3:0]  strobes;
  logic        blank;
  logic        one_hot;
  logic        pat_ok;
  logic [3:0]  nibble;
  logic [15:0] next_shadow;
  logic [3:0]  next_seen;

  assign changed = ({s_seg, s_dig} != {p_seg, p_dig});
  // Fires only on the STABLE_CYCLES-1 -> STABLE_CYCLES step, so once per dwell.
  assign accept  = !changed && (stab == STAB_MAX - 8'd1);
  assign strobes = ~s_dig;
  assign blank   = (strobes == 4'b0000);
  assign one_hot = !blank && ((strobes & (strobes - 4'd1)) == 4'b0000);

  always_comb begin
    pat_ok = 1'b1;
    nibble = 4'h0;
    case (s_seg)
      8'hC0: nibble = 4'h0;
      8'hF9: nibble = 4'h1;
      8'hA4: nibble = 4'h2;
      8'hB0: nibble = 4'h3;
      8'h99: nibble = 4'h4;
      8'h92: nibble = 4'h5;
      8'h82: nibble = 4'h6;
      8'hF8: nibble = 4'h7;
      8'h80: nibble = 4'h8;
      8'h90: nibble = 4'h9;
      8'h88: nibble = 4'hA;
      8'h83: nibble = 4'hB;
      8'hC6: nibble = 4'hC;
      8'hA1: nibble = 4'hD;
      8'h86: nibble = 4'hE;
      8'h8E: nibble = 4'hF;
      default: pat_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_shadow = shadow;
    next_seen   = digit_seen;
    for (int i = 0; i < 4; i++) begin
      if (strobes[i]) begin
        next_shadow[4*i +: 4] = nibble;
        next_seen[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s_seg         <= 8'hFF;
      p_seg         <= 8'hFF;
      s_dig         <= 4'hF;
      p_dig         <= 4'hF;
      stab          <= 8'd0;
      shadow        <= 16'h0000;
      number        <= 16'h0000;
      number_valid  <= 1'b0;
      digit_seen    <= 4'b0000;
      pattern_error <= 1'b0;
      strobe_error  <= 1'b0;
    end else begin
      s_seg         <= abcdefgh;
      s_dig         <= digit;
      p_seg         <= s_seg;
      p_dig         <= s_dig;
      number_valid  <= 1'b0;
      pattern_error <= 1'b0;
      strobe_error  <= 1'b0;

      if (changed)
        stab <= 8'd0;
      else if (stab != STAB_MAX)
        stab <= stab + 8'd1;

      if (accept && !blank) begin
        if (!one_hot) begin
          strobe_error <= 1'b1;
        end else if (!pat_ok) begin
          pattern_error <= 1'b1;
        end else begin
          shadow <= next_shadow;
          if (next_seen == 4'b1111) begin
            number       <= next_shadow;
            number_valid <= 1'b1;
            digit_seen   <= 4'b0000;
          end else begin
            digit_seen <= next_seen;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_4_digits_decoder.sv
// Directed bench for seven_segment_4_digits_decoder: hand-computed frames, glitches, errors and resets.
module tb_seven_segment_4_digits_decoder;

  logic        clock;
  logic        reset;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic [15:0] number;
  logic        number_valid;
  logic [3:0]  digit_seen;
  logic        pattern_error;
  logic        strobe_error;

  int total = 0;
  int bad   = 0;
  int nv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int multi = 0, hold_bad = 0;
  int nv0, pe0, se0;
  logic [15:0] prev_number = 16'h0000;

  seven_segment_4_digits_decoder #(.STABLE_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .abcdefgh      (abcdefgh),
    .digit         (digit),
    .number        (number),
    .number_valid  (number_valid),
    .digit_seen    (digit_seen),
    .pattern_error (pattern_error),
    .strobe_error  (strobe_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs at a falling edge and observe n subsequent falling edges.
  task automatic drive(input logic [3:0] d, input logic [7:0] s, input int n);
    digit    = d;
    abcdefgh = s;
    repeat (n) begin
      @(negedge clock);
      if (number_valid)  nv_cnt++;
      if (pattern_error) pe_cnt++;
      if (strobe_error)  se_cnt++;
      if ((32'(number_valid) + 32'(pattern_error) + 32'(strobe_error)) > 1) multi++;
      if (!reset && number != prev_number && !number_valid) hold_bad++;
      prev_number = number;
    end
  endtask

  task automatic snap();
    nv0 = nv_cnt;
    pe0 = pe_cnt;
    se0 = se_cnt;
  endtask

  initial begin
    reset    = 1'b1;
    digit    = 4'($urandom);
    abcdefgh = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("reset_outs", {number, number_valid, digit_seen, pattern_error, strobe_error}, 32'd0);
      digit    = 4'($urandom);
      abcdefgh = 8'($urandom);
    end
    reset = 1'b0;
    drive(4'b1111, 8'hFF, 1);
    chk("post_reset_outs", {number, number_valid, digit_seen, pattern_error, strobe_error}, 32'd0);
    drive(4'b1111, 8'hFF, 8);

    // Full frame 3210 in order
    snap();
    drive(4'b1110, 8'hC0, 10); chk("frame_seen0", digit_seen, 4'b0001);
    drive(4'b1101, 8'hF9, 10); chk("frame_seen1", digit_seen, 4'b0011);
    drive(4'b1011, 8'hA4, 10); chk("frame_seen2", digit_seen, 4'b0111);
    drive(4'b0111, 8'hB0, 10); chk("frame_seen3", digit_seen, 4'b0000);
    chk("frame_number", number, 16'h3210);
    chk("frame_valid_cnt", nv_cnt - nv0, 1);

    // Dwell boundaries: 4 held cycles are too short; accept lands on the 6th edge
    drive(4'b1111, 8'hFF, 8);
    drive(4'b1110, 8'hC0, 4);
    drive(4'b1111, 8'hFF, 8);
    chk("short_hold_seen", digit_seen, 4'b0000);
    drive(4'b1110, 8'hC0, 5);
    chk("latency_before", digit_seen, 4'b0000);
    drive(4'b1110, 8'hC0, 1);
    chk("latency_at", digit_seen, 4'b0001);
    drive(4'b1110, 8'hC0, 10);

    // Glitch: 5 shown for 3 cycles must never land
    snap();
    drive(4'b1110, 8'h92, 3);
    drive(4'b1110, 8'h99, 10);
    chk("glitch_seen", digit_seen, 4'b0001);
    drive(4'b1101, 8'hF9, 10);
    drive(4'b1011, 8'hA4, 10);
    drive(4'b0111, 8'hB0, 10);
    chk("glitch_number", number, 16'h3214);
    chk("glitch_valid_cnt", nv_cnt - nv0, 1);

    // Errors
    snap();
    drive(4'b1110, 8'hFF, 10);
    chk("pat_err_cnt", pe_cnt - pe0, 1);
    chk("pat_err_seen", digit_seen, 4'b0000);
    drive(4'b1100, 8'hC0, 10);
    chk("strobe_err_cnt", se_cnt - se0, 1);
    chk("strobe_err_pe", pe_cnt - pe0, 1);
    snap();
    drive(4'b1111, 8'hC0, 10);
    chk("blank_pulses", (nv_cnt - nv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    chk("blank_seen", digit_seen, 4'b0000);

    // Overwrite and out-of-order capture
    snap();
    drive(4'b1011, 8'h92, 10);
    drive(4'b1011, 8'h8E, 10);
    chk("ovw_seen", digit_seen, 4'b0100);
    drive(4'b1110, 8'hC0, 10);
    drive(4'b0111, 8'h88, 10);
    chk("ovw_seen3", digit_seen, 4'b1101);
    drive(4'b1101, 8'hF9, 10);
    chk("ovw_number", number, 16'hAF10);
    chk("ovw_valid_cnt", nv_cnt - nv0, 1);
    chk("ovw_seen_clr", digit_seen, 4'b0000);

    // Reset mid-frame
    drive(4'b1110, 8'hC0, 10);
    drive(4'b1101, 8'hF9, 10);
    drive(4'b1011, 8'hA4, 10);
    chk("mid_seen", digit_seen, 4'b0111);
    reset = 1'b1;
    drive(4'b1011, 8'hA4, 2);
    reset = 1'b0;
    chk("mid_reset_number", number, 16'h0000);
    snap();
    drive(4'b0111, 8'hB0, 10);
    chk("mid_seen_after", digit_seen, 4'b1000);
    chk("mid_valid_cnt", nv_cnt - nv0, 0);

    // Back-to-back driver scan showing FEDC
    snap();
    for (int f = 0; f < 3; f++) begin
      drive(4'b0111, 8'h8E, 8);
      drive(4'b1110, 8'hC6, 8);
      drive(4'b1101, 8'hA1, 8);
      drive(4'b1011, 8'h86, 8);
    end
    chk("scan_number", number, 16'hFEDC);
    chk("scan_valid_cnt", nv_cnt - nv0, 3);

    chk("pulse_exclusive", multi, 0);
    chk("number_hold", hold_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
